wb_mem_master_bridge: RTL and testbench

- Converts the MEM-stage / atomic-controller level-style memory request (mem_read, mem_write, mem_addr, mem_wdata) into Wishbone B4 classic single-word cycles.
- Returns mem_rdata and a one-cycle mem_ack pulse to the upstream atomic access controller.
- Sits directly downstream of that controller, between it and the SoC Wishbone interconnect.
- Adds bus-error and timeout termination so a hung slave cannot stall the pipeline forever.

---
 rtl/wb_mem_master_bridge.sv | 135 +++++++++++++
 tb/tb_wb_mem_master_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_master_bridge.sv
// Level-style MEM-stage request to Wishbone B4 classic single-word master bridge.
// Latency: request sampled in IDLE -> stb next cycle; mem_ack one cycle after ack/err/timeout.
// Backpressure: one outstanding cycle; requests are not sampled again until the bridge is back in IDLE.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   mem_read/mem_write  : level requests (write wins when both are set)
//   mem_addr/mem_wdata  : word address (bits [1:0] ignored), write data
//   mem_rdata/mem_ack   : registered read data, one-cycle completion pulse
//   bus_err             : pulses with mem_ack when ended by wb_err_i or timeout
//   wb_*                : Wishbone master side, all outputs registered
module wb_mem_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          TIMEOUT_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        bus_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [31:0]   mem_rdata_nxt, wb_adr_nxt, wb_dat_nxt;
  logic [3:0]    wb_sel_nxt;
  logic          mem_ack_nxt, bus_err_nxt, wb_cyc_nxt, wb_stb_nxt, wb_we_nxt;
  logic          tmo_hit, term_err;

  // Byte offset is meaningless for word-only accesses.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr[1:0];

  assign tmo_hit  = TIMEOUT_EN && (tmo_cnt == TMO_LAST);
  // Err beats ack; a timeout only counts when the slave did not respond.
  assign term_err = wb_err_i || (!wb_ack_i && tmo_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      mem_rdata <= '0;
      mem_ack   <= 1'b0;
      bus_err   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
    end else begin
      state     <= state_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      mem_rdata <= mem_rdata_nxt;
      mem_ack   <= mem_ack_nxt;
      bus_err   <= bus_err_nxt;
      wb_cyc_o  <= wb_cyc_nxt;
      wb_stb_o  <= wb_stb_nxt;
      wb_we_o   <= wb_we_nxt;
      wb_adr_o  <= wb_adr_nxt;
      wb_dat_o  <= wb_dat_nxt;
      wb_sel_o  <= wb_sel_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tmo_cnt_nxt   = tmo_cnt;
    mem_rdata_nxt = mem_rdata;
    mem_ack_nxt   = 1'b0;
    bus_err_nxt   = 1'b0;
    wb_cyc_nxt    = wb_cyc_o;
    wb_stb_nxt    = wb_stb_o;
    wb_we_nxt     = wb_we_o;
    wb_adr_nxt    = wb_adr_o;
    wb_dat_nxt    = wb_dat_o;
    wb_sel_nxt    = wb_sel_o;

    case (state)
      IDLE: begin
        if (mem_write || (mem_read != 2'b00)) begin
          wb_cyc_nxt  = 1'b1;
          wb_stb_nxt  = 1'b1;
          wb_we_nxt   = mem_write;
          wb_adr_nxt  = {mem_addr[31:2], 2'b00};
          wb_dat_nxt  = mem_wdata;
          wb_sel_nxt  = 4'hF;
          tmo_cnt_nxt = '0;
          state_nxt   = BUS;
        end
      end
      BUS: begin
        if (wb_ack_i || wb_err_i || tmo_hit) begin
          wb_cyc_nxt  = 1'b0;
          wb_stb_nxt  = 1'b0;
          mem_ack_nxt = 1'b1;
          bus_err_nxt = term_err;
          if (!wb_we_o) begin
            mem_rdata_nxt = term_err ? 32'h0 : wb_dat_i;
          end
          state_nxt = DONE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + CW'(1);
        end
      end
      DONE: begin
        // Request lines are deliberately not looked at here so a held
        // request cannot launch back-to-back bus cycles.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_mem_master_bridge.sv
module tb_wb_mem_master_bridge;

  typedef struct {
    logic [1:0]  rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdat;
    int          waits;
    logic        ack;
    logic        err;
  } txn_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_read;
  logic        mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, bus_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i;

  // Second instance with a short timeout and a slave that never answers.
  logic [1:0]  t_read;
  logic        t_write;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic        t_ack, t_berr, t_cyc, t_stb, t_we;
  logic [31:0] t_adr, t_dato;
  logic [3:0]  t_sel;
  logic [31:0] t_dati;
  logic        t_acki, t_erri;

  int n_chk = 0;
  int n_err = 0;
  int n_ack = 0;
  int n_rise = 0;

  req_t q_req[$];
  rsp_t q_rsp[$];
  txn_t q_slv[$];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  wb_mem_master_bridge dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  wb_mem_master_bridge #(.TIMEOUT_CYCLES(4), .TIMEOUT_EN(1'b1)) u_tmo (
    .clk(clk), .rst(rst),
    .mem_read(t_read), .mem_write(t_write), .mem_addr(t_addr), .mem_wdata(t_wdata),
    .mem_rdata(t_rdata), .mem_ack(t_ack), .bus_err(t_berr),
    .wb_cyc_o(t_cyc), .wb_stb_o(t_stb), .wb_we_o(t_we), .wb_adr_o(t_adr),
    .wb_dat_o(t_dato), .wb_sel_o(t_sel), .wb_dat_i(t_dati), .wb_ack_i(t_acki),
    .wb_err_i(t_erri)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_ev(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Reference model: one bus cycle per request, write wins, err or ack+err
  // reports an error, a read returns slave data (or 0 on error), a write
  // leaves the last read value in place.
  task automatic expect_txn(input txn_t t);
    req_t r;
    rsp_t s;
    r.we  = t.wr;
    r.adr = t.addr & 32'hFFFF_FFFC;
    r.dat = t.wdata;
    q_req.push_back(r);
    q_slv.push_back(t);
    if (!t.wr) exp_rdata = t.err ? 32'h0 : t.rdat;
    s.rdata = exp_rdata;
    s.err   = t.err;
    q_rsp.push_back(s);
  endtask

  task automatic drop_req();
    mem_read  = 2'b00;
    mem_write = 1'b0;
    mem_addr  = $urandom;
    mem_wdata = $urandom;
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic issue(input txn_t t);
    int lat;
    bit got;
    expect_txn(t);
    mem_read  = t.rd;
    mem_write = t.wr;
    mem_addr  = t.addr;
    mem_wdata = t.wdata;
    lat = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (mem_ack) got = 1;
    end
    chk("ack_seen", {31'b0, got}, 32'd1);
    if (got) chk("latency", lat, 2 + t.waits);
    drop_req();
    @(posedge clk); #1;
  endtask

  function automatic txn_t mk(input logic [1:0] rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdat,
                              input int waits, input logic ack, input logic err);
    txn_t t;
    t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdat = rdat;
    t.waits = waits; t.ack = ack; t.err = err;
    return t;
  endfunction

  // Slave model: answers each new strobe with the parameters queued by stimulus.
  initial begin
    txn_t t;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (wb_stb_o && !rst) begin
        if (q_slv.size() == 0) begin
          fail_ev("unexpected_bus_cycle");
        end else begin
          t = q_slv.pop_front();
          for (int i = 0; i < t.waits; i++) begin
            @(posedge clk); #1;
          end
          wb_ack_i = t.ack;
          wb_err_i = t.err;
          wb_dat_i = t.rdat;
          @(posedge clk); #1;
          wb_ack_i = 1'b0;
          wb_err_i = 1'b0;
          wb_dat_i = $urandom;
        end
      end
    end
  end

  // Monitor: checks bus requests and completions against the queues.
  initial begin
    req_t cur;
    rsp_t s;
    logic prev_stb, prev_ack;
    prev_stb = 1'b0;
    prev_ack = 1'b0;
    cur = '{we: 1'b0, adr: 32'h0, dat: 32'h0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wb_stb_o && !prev_stb) begin
          n_rise++;
          if (q_req.size() == 0) begin
            fail_ev("unexpected_stb");
          end else begin
            cur = q_req.pop_front();
            chk("wb_cyc", {31'b0, wb_cyc_o}, 32'd1);
            chk("wb_we", {31'b0, wb_we_o}, {31'b0, cur.we});
            chk("wb_adr", wb_adr_o, cur.adr);
            chk("wb_sel", {28'b0, wb_sel_o}, 32'hF);
            if (cur.we) chk("wb_dat", wb_dat_o, cur.dat);
          end
        end else if (wb_stb_o) begin
          chk("hold_we", {31'b0, wb_we_o}, {31'b0, cur.we});
          chk("hold_adr", wb_adr_o, cur.adr);
          if (cur.we) chk("hold_dat", wb_dat_o, cur.dat);
        end
        if (mem_ack) begin
          n_ack++;
          if (prev_ack) fail_ev("mem_ack_two_cycles");
          chk("cyc_in_done", {31'b0, wb_cyc_o}, 32'd0);
          if (q_rsp.size() == 0) begin
            fail_ev("unexpected_mem_ack");
          end else begin
            s = q_rsp.pop_front();
            chk("mem_rdata", mem_rdata, s.rdata);
            chk("bus_err", {31'b0, bus_err}, {31'b0, s.err});
          end
        end else if (bus_err) begin
          fail_ev("bus_err_without_ack");
        end
      end
      prev_stb = wb_stb_o;
      prev_ack = mem_ack;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    txn_t t;
    int a0, r0, n, kind;
    bit got;
    rst = 1'b1;
    drop_req();
    t_read = 2'b00; t_write = 1'b0; t_addr = 32'h0; t_wdata = 32'h0;
    t_dati = 32'hA5A5_A5A5; t_acki = 1'b0; t_erri = 1'b0;
    exp_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_outs", {26'b0, mem_ack, bus_err, wb_cyc_o, wb_stb_o, wb_we_o, 1'b0}, 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_sel", {28'b0, wb_sel_o}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait read.
    issue(mk(2'b01, 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 1'b0));
    // Write with three wait states; read data must survive.
    issue(mk(2'b00, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h5555_0000, 3, 1'b1, 1'b0));
    // Read and write together: a single write cycle.
    issue(mk(2'b01, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 32'h7777_7777, 1, 1'b1, 1'b0));
    // Error on a read clears read data.
    issue(mk(2'b10, 1'b0, 32'h0000_0108, 32'h0, 32'h9999_9999, 2, 1'b0, 1'b1));
    issue(mk(2'b11, 1'b0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 0, 1'b1, 1'b0));
    // Ack and err together report an error.
    issue(mk(2'b01, 1'b0, 32'h0000_0300, 32'h0, 32'h1111_2222, 1, 1'b1, 1'b1));

    // Request held for nine edges against an always-ack slave: three cycles.
    a0 = n_ack;
    r0 = n_rise;
    for (int i = 0; i < 3; i++)
      expect_txn(mk(2'b01, 1'b0, 32'h0000_0400, 32'h0, $urandom, 0, 1'b1, 1'b0));
    mem_read = 2'b01;
    mem_addr = 32'h0000_0400;
    repeat (9) begin @(posedge clk); #1; end
    drop_req();
    repeat (4) begin @(posedge clk); #1; end
    chk("held_acks", n_ack - a0, 32'd3);
    chk("held_cycles", n_rise - r0, 32'd3);

    // Timeout with a silent slave on the short-timeout instance.
    t_read = 2'b01;
    t_addr = 32'h0000_0500;
    n = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (t_cyc) n++;
      if (t_ack) begin
        got = 1;
        chk("tmo_berr", {31'b0, t_berr}, 32'd1);
        chk("tmo_rdata", t_rdata, 32'h0);
        chk("tmo_cyc_low", {31'b0, t_cyc}, 32'd0);
      end
    end
    t_read = 2'b00;
    chk("tmo_ack_seen", {31'b0, got}, 32'd1);
    chk("tmo_bus_cycles", n, 32'd4);
    @(posedge clk); #1;
    chk("tmo_ack_pulse", {30'b0, t_ack, t_berr}, 32'd0);

    // Reset in the middle of a bus cycle; the slave acks late, into IDLE.
    begin
      req_t r;
      r.we = 1'b0; r.adr = 32'h0000_0600; r.dat = 32'h0;
      q_req.push_back(r);
      q_slv.push_back(mk(2'b01, 1'b0, 32'h0000_0600, 32'h0, 32'h4444_4444, 3, 1'b1, 1'b0));
    end
    mem_read = 2'b01;
    mem_addr = 32'h0000_0602;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_stb", {31'b0, wb_stb_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drop_req();
    exp_rdata = 32'h0;
    chk("midrst_rdata", mem_rdata, 32'h0);
    chk("midrst_outs", {27'b0, mem_ack, bus_err, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h0);
    chk("midrst_adr", wb_adr_o, 32'h0);
    a0 = n_ack;
    repeat (5) begin @(posedge clk); #1; end
    chk("midrst_no_ack", n_ack - a0, 32'd0);
    issue(mk(2'b01, 1'b0, 32'h0000_0700, 32'h0, 32'h8765_4321, 1, 1'b1, 1'b0));

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      n = $urandom_range(0, 2);
      t.wr    = (n != 0);
      t.rd    = (n == 1) ? 2'b00 : 2'($urandom_range(1, 3));
      t.addr  = $urandom;
      t.wdata = $urandom;
      t.rdat  = $urandom;
      t.waits = $urandom_range(0, 3);
      t.ack   = (kind <= 6) || (kind == 9);
      t.err   = (kind >= 7);
      issue(t);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("q_rsp_drained", q_rsp.size(), 32'd0);
    chk("q_req_drained", q_req.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
